instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue_pkg.sv | 19 +
 rtl/instr_fetch_queue_fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch_queue.sv | 108 ++++++++++
 tb/tb_instr_fetch_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
// Holds the fetch FSM encoding, the PC step and the queue entry layout.
package instr_fetch_queue_pkg;

  localparam int          DEFAULT_DEPTH = 4;
  localparam logic [31:0] PC_INCR       = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2
  } fetchState_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetchEntry_t;

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Circular buffer of fetched {pc, instr} entries with a synchronous clear.
// Callers never push when full nor pop when empty.
module fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int  DEPTH = DEFAULT_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  fetchEntry_t   pushData_i,
  output fetchEntry_t   headData_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  fetchEntry_t   mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q;
  logic [PW-1:0] rdPtr_q;
  logic [CW-1:0] count_q;

  // Storage is zeroed on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= wrPtr_q + PW'(1);
      end
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + CW'(1);
      end else if (!push_i && pop_i) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign headData_o = mem_q[rdPtr_q];
  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch unit: one-outstanding-request fetch FSM feeding a FIFO
// that the IF/ID stage drains; a flush empties the queue and redirects fetch.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  output logic          dec_valid,
  output logic [31:0]   dec_instr,
  output logic [31:0]   dec_pc,
  input  logic          dec_ready,
  input  logic          flush,
  input  logic [31:0]   flush_pc,
  output logic [CW-1:0] fill_count
);

  fetchState_e state_q, state_d;
  logic [31:0] fetchPc_q, fetchPc_d;
  logic [31:0] reqAddr_q, reqAddr_d;
  logic        pushEn;
  logic        popEn;
  logic        fifoFull;
  logic        fifoEmpty;
  fetchEntry_t pushEntry;
  fetchEntry_t headEntry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      fetchPc_q <= RESET_PC;
      reqAddr_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      reqAddr_q <= reqAddr_d;
    end
  end

  // A request only issues when the queue has room; since nothing else pushes
  // while it is outstanding, the completing push can never find the queue full.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    reqAddr_d = reqAddr_q;
    pushEn    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (flush) begin
          fetchPc_d = flush_pc;
        end else if (!fifoFull) begin
          state_d   = ST_WAIT;
          reqAddr_d = fetchPc_q;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          fetchPc_d = flush_pc;
          state_d   = imem_ready ? ST_IDLE : ST_DISCARD;
        end else if (imem_ready) begin
          pushEn    = 1'b1;
          fetchPc_d = reqAddr_q + PC_INCR;
          state_d   = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (flush) begin
          fetchPc_d = flush_pc;
        end
        if (imem_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_req        = (state_q != ST_IDLE);
  assign imem_addr       = reqAddr_q;
  assign pushEntry.pc    = reqAddr_q;
  assign pushEntry.instr = imem_rdata;
  assign popEn           = dec_valid && dec_ready && !flush;

  fetch_fifo #(.DEPTH(DEPTH)) fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (pushEn),
    .pop_i      (popEn),
    .clear_i    (flush),
    .pushData_i (pushEntry),
    .headData_o (headEntry),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fill_count)
  );

  assign dec_valid = !fifoEmpty;
  assign dec_instr = headEntry.instr;
  assign dec_pc    = headEntry.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a transaction-level model
// built from a queue of fetched words and a single outstanding-request record.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [2:0]  fill_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } refEntry_t;

  refEntry_t   refQ[$];
  bit          refOut;
  bit          refDrop;
  logic [31:0] refAddr;
  logic [31:0] refPc;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dec_valid  (dec_valid),
    .dec_instr  (dec_instr),
    .dec_pc     (dec_pc),
    .dec_ready  (dec_ready),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    refQ.delete();
    refOut  = 1'b0;
    refDrop = 1'b0;
    refAddr = RESET_PC;
    refPc   = RESET_PC;
  endtask

  task automatic compareModel();
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, refOut});
    if (refOut) checkOutput("imem_addr", imem_addr, refAddr);
    checkOutput("dec_valid", {31'b0, dec_valid}, {31'b0, refQ.size() > 0});
    if (refQ.size() > 0) begin
      checkOutput("dec_pc", dec_pc, refQ[0].pc);
      checkOutput("dec_instr", dec_instr, refQ[0].instr);
    end
    checkOutput("fill_count", {29'b0, fill_count}, refQ.size());
  endtask

  // One clock of the reference: what happens to the queue, the fetch PC and
  // the single outstanding request given this cycle's inputs.
  task automatic modelStep(input bit f, input logic [31:0] fpc, input bit rdy, input bit drdy, input logic [31:0] rdata);
    int          preSize;
    logic [31:0] prePc;
    bit          doPush;
    preSize = refQ.size();
    prePc   = refPc;
    doPush  = 1'b0;
    if (refOut && rdy) begin
      doPush  = !refDrop && !f;
      refOut  = 1'b0;
      refDrop = 1'b0;
    end else if (refOut && f) begin
      refDrop = 1'b1;
    end else if (!refOut && !f && preSize < DEPTH) begin
      refOut  = 1'b1;
      refAddr = prePc;
    end
    if (f) begin
      refQ.delete();
      refPc = fpc;
    end else begin
      if (preSize > 0 && drdy) void'(refQ.pop_front());
      if (doPush) begin
        refQ.push_back('{pc: refAddr, instr: rdata});
        refPc = refAddr + 32'd4;
      end
    end
  endtask

  task automatic applyStimulus(input bit f, input logic [31:0] fpc, input bit rdy, input bit drdy, input logic [31:0] rdata);
    compareModel();
    flush      = f;
    flush_pc   = fpc;
    imem_ready = rdy;
    dec_ready  = drdy;
    imem_rdata = rdata;
    modelStep(f, fpc, rdy, drdy, rdata);
    @(negedge clk);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_imem_addr", imem_addr, RESET_PC);
    checkOutput("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
    checkOutput("rst_dec_instr", dec_instr, 32'd0);
    checkOutput("rst_dec_pc", dec_pc, 32'd0);
    checkOutput("rst_fill_count", {29'b0, fill_count}, 32'd0);
  endtask

  initial begin
    modelReset();
    repeat (3) @(negedge clk);
    checkResetValues();
    reset = 1'b0;

    // Streaming fetch with an always-ready memory and decoder.
    repeat (20) applyStimulus(1'b0, '0, 1'b1, 1'b1, $urandom);

    // Stall the decoder until the queue fills, release one entry, stall again.
    repeat (14) applyStimulus(1'b0, '0, 1'b1, 1'b0, $urandom);
    checkOutput("full_fill_count", {29'b0, fill_count}, DEPTH);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, $urandom);
    repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b0, $urandom);

    // Flush during an outstanding request whose data returns three cycles late.
    repeat (6) applyStimulus(1'b0, '0, 1'b0, 1'b1, $urandom);
    for (int n = 0; n < 10 && !refOut; n++) applyStimulus(1'b0, '0, 1'b0, 1'b1, $urandom);
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, 1'b1, $urandom);
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b1, $urandom);
    repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b0, $urandom);

    // Flush coinciding with a returning word and a pop.
    for (int n = 0; n < 10 && !(refOut && refQ.size() > 0); n++)
      applyStimulus(1'b0, '0, refQ.size() == 0, 1'b0, $urandom);
    applyStimulus(1'b1, 32'h0000_0200, 1'b1, 1'b1, $urandom);
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b1, $urandom);

    // Fetch PC wrapping past the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, $urandom);
    repeat (10) applyStimulus(1'b0, '0, 1'b1, 1'b1, $urandom);

    // Random traffic with occasional redirects.
    for (int n = 0; n < 500; n++) begin
      bit          f;
      logic [31:0] fpc;
      f   = ($urandom_range(0, 15) == 0);
      fpc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) fpc = 32'hFFFF_FFF8;
      applyStimulus(f, fpc, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom);
    end

    // Reset while a request is outstanding with three entries queued.
    for (int n = 0; n < 40 && !(refOut && refQ.size() == 3); n++)
      applyStimulus(1'b0, '0, refQ.size() < 3, 1'b0, $urandom);
    compareModel();
    checkOutput("pre_reset_fill", {29'b0, fill_count}, 32'd3);
    checkOutput("pre_reset_req", {31'b0, imem_req}, 32'd1);
    reset      = 1'b1;
    flush      = 1'b0;
    imem_ready = 1'b0;
    dec_ready  = 1'b0;
    #1;
    checkResetValues();
    @(negedge clk);
    checkResetValues();
    reset = 1'b0;
    modelReset();
    repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b1, $urandom);
    compareModel();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
